// File: rtl/mdr_engine_pkg.sv
// Shared types and constants for the multiply / divide / square-root engine.
//   op_e        : operation select carried on the 2-bit op port
//   mdr_state_e : engine control states
//   DW_DEFAULT  : default operand width
package mdr_engine_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_DIV  = 2'd1,
    OP_SQRT = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_ERR  = 2'd3
  } mdr_state_e;

endpackage

// File: rtl/mdr_sign_fix.sv
// Two's-complement conditional negation. Used both to turn signed operands
// into magnitudes and to put the sign back onto magnitude results.
//   value  : input word
//   negate : 1 = output the two's-complement negation of value
//   y      : value or -value
module mdr_sign_fix #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] y
);

  assign y = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mdr_engine.sv
// Sequential multiply / divide / square-root engine with serial operand load.
//   clk, rst     : clock and asynchronous active-low reset
//   load, data   : write data into A then B (pointer toggles per load)
//   op           : op_e operation select, latched at start
//   signed_mode  : two's-complement operands, latched at start
//   start        : begin an operation (only while ready)
//   ready        : engine idle
//   done         : one-cycle pulse when result/remainder/error update
//   error        : status of the last operation, held until next done
//   result       : product low / quotient / root
//   remainder    : product high / remainder / A - root^2
module mdr_engine
  import mdr_engine_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [1:0]    op,
  input  logic          signed_mode,
  input  logic          start,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic          done,
  output logic          error,
  output logic [DW-1:0] result,
  output logic [DW-1:0] remainder
);

  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] LAST_FULL = CW'(DW - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(DW / 2 - 1);
  localparam logic [DW-1:0] MOST_NEG  = {1'b1, {(DW-1){1'b0}}};

  mdr_state_e    state;
  op_e           op_q;
  logic          ptr;             // 0: next load goes to A, 1: to B
  logic [DW-1:0] opa, opb;
  logic          neg_q, neg_r;    // sign of product/quotient, of remainder
  logic [DW-1:0] acc_hi, acc_lo;  // working accumulator pair
  logic [DW-1:0] aux;             // multiplicand, divisor, or partial root
  logic [CW-1:0] cnt;

  assign ready = (state == ST_IDLE);

  // Start-time decode: magnitudes and error detection.
  op_e           op_in;
  logic          a_neg, b_neg;
  logic [DW-1:0] mag_a, mag_b;
  logic          div_zero, div_ovf, sqrt_neg, start_err;
  logic [DW-1:0] err_res, err_rem;

  assign op_in     = op_e'(op);
  assign a_neg     = signed_mode & opa[DW-1];
  assign b_neg     = signed_mode & opb[DW-1];
  assign div_zero  = (op_in == OP_DIV) && (opb == '0);
  assign div_ovf   = (op_in == OP_DIV) && signed_mode && (opa == MOST_NEG) && (opb == '1);
  assign sqrt_neg  = (op_in == OP_SQRT) && a_neg;
  assign start_err = div_zero || div_ovf || sqrt_neg || (op_in == OP_RSVD);

  mdr_sign_fix #(.W(DW)) u_mag_a (.value(opa), .negate(a_neg), .y(mag_a));
  mdr_sign_fix #(.W(DW)) u_mag_b (.value(opb), .negate(b_neg), .y(mag_b));

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    err_res = '0;
    err_rem = '0;
    if (div_zero) begin
      err_res = '1;
      err_rem = opa;
    end else if (div_ovf) begin
      err_res = MOST_NEG;
    end else if (sqrt_neg) begin
      err_rem = opa;
    end
  end

  // One iteration step of each algorithm.
  logic [DW:0]   mul_sum;
  logic [DW:0]   div_shift;
  logic          div_ge;
  logic [DW-1:0] div_diff;
  logic [DW+1:0] sq_shift, sq_trial;
  logic          sq_ge;
  logic [DW-1:0] sq_diff;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, aux} : '0);
  assign div_shift = {acc_hi, acc_lo[DW-1]};
  assign div_ge    = div_shift >= {1'b0, aux};
  // The difference is below the divisor, so the low DW bits are exact.
  assign div_diff  = div_shift[DW-1:0] - aux;
  assign sq_shift  = {acc_hi, acc_lo[DW-1:DW-2]};
  assign sq_trial  = {aux, 2'b01};
  assign sq_ge     = sq_shift >= sq_trial;
  assign sq_diff   = sq_shift[DW-1:0] - sq_trial[DW-1:0];

  // Sign restoration of the finished magnitudes.
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   quot_fix, rem_fix;
  logic [DW-1:0]   fix_res, fix_rem;

  mdr_sign_fix #(.W(2*DW)) u_fix_prod (.value({acc_hi, acc_lo}), .negate(neg_q), .y(prod_fix));
  mdr_sign_fix #(.W(DW))   u_fix_quot (.value(acc_lo), .negate(neg_q), .y(quot_fix));
  mdr_sign_fix #(.W(DW))   u_fix_rem  (.value(acc_hi), .negate(neg_r), .y(rem_fix));

  always_comb begin
    fix_res = '0;
    fix_rem = '0;
    case (op_q)
      OP_MUL:  begin fix_res = prod_fix[DW-1:0]; fix_rem = prod_fix[2*DW-1:DW]; end
      OP_DIV:  begin fix_res = quot_fix;         fix_rem = rem_fix;             end
      OP_SQRT: begin fix_res = aux;              fix_rem = acc_hi;              end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values present before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_MUL;
      ptr       <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      aux       <= '0;
      cnt       <= '0;
      result    <= '0;
      remainder <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr   <= 1'b0;
            op_q  <= op_in;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= '0;
            if (start_err) begin
              // Error outputs parked in the accumulator until ERR publishes them.
              acc_lo <= err_res;
              acc_hi <= err_rem;
              state  <= ST_ERR;
            end else begin
              acc_hi <= '0;
              acc_lo <= (op_in == OP_MUL) ? mag_b : mag_a;
              aux    <= (op_in == OP_MUL) ? mag_a : (op_in == OP_DIV) ? mag_b : '0;
              state  <= ST_RUN;
            end
          end else if (load) begin
            if (ptr) opb <= data;
            else     opa <= data;
            ptr <= ~ptr;
          end
        end
        ST_RUN: begin
          case (op_q)
            OP_MUL: {acc_hi, acc_lo} <= {mul_sum, acc_lo[DW-1:1]};
            OP_DIV: begin
              acc_hi <= div_ge ? div_diff : div_shift[DW-1:0];
              acc_lo <= {acc_lo[DW-2:0], div_ge};
            end
            OP_SQRT: begin
              acc_hi <= sq_ge ? sq_diff : sq_shift[DW-1:0];
              acc_lo <= {acc_lo[DW-3:0], 2'b00};
              aux    <= {aux[DW-2:0], sq_ge};
            end
            default: ;
          endcase
          cnt <= cnt + CW'(1);
          if (cnt == ((op_q == OP_SQRT) ? LAST_HALF : LAST_FULL)) state <= ST_FIX;
        end
        ST_FIX: begin
          result    <= fix_res;
          remainder <= fix_rem;
          error     <= 1'b0;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_ERR: begin
          result    <= acc_lo;
          remainder <= acc_hi;
          error     <= 1'b1;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
